mpu_seq: RTL and testbench

Program sequencer for the MPU instruction pointer counter. Drives the counter's en/incr/load/data controls, fetches instruction words over a req/ack handshake, and hands each word to the decoder. Applies decoder outcomes: sequential advance, jump, call or return, using an internal return-address stack, or halt. Sits between the MPU top level (start/stop), instruction memory and the decoder.

---
 rtl/mpu_seq.sv | 185 ++++++++++++++++++
 tb/tb_mpu_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_seq.sv
// mpu_seq: program sequencer for the MPU instruction pointer counter.
// Fetches instruction words over a req/ack handshake, presents each word to
// the decoder, then applies the decoder outcome to the external counter:
// sequential advance, jump, call/return via a return-address stack, or halt.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   start, start_addr, stop   run control from the MPU top level
//   ip                        current counter value
//   ip_en/ip_load/ip_incr/ip_data  counter controls (combinational)
//   mem_req/mem_addr/mem_ack/mem_data  instruction fetch handshake
//   instr, instr_valid        latched word to the decoder
//   exec_*                    decoder outcome, valid with exec_done
//   busy, halted, err, sp     status
//
// Optional build macro MPU_SEQ_STEP_EN adds single-step support:
//   step_mode, step inputs, paused output and a PAUSE state.

module mpu_seq #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned STACK_AW    = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic [15:0]         start_addr,
  input  logic                stop,
  input  logic [15:0]         ip,
  output logic                ip_en,
  output logic                ip_load,
  output logic [15:0]         ip_incr,
  output logic [15:0]         ip_data,
  output logic                mem_req,
  output logic [15:0]         mem_addr,
  input  logic                mem_ack,
  input  logic [15:0]         mem_data,
  output logic [15:0]         instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic [15:0]         exec_len,
  input  logic                exec_jmp,
  input  logic                exec_call,
  input  logic                exec_ret,
  input  logic                exec_halt,
  input  logic [15:0]         exec_target,
  output logic                busy,
  output logic                halted,
  output logic                err,
  output logic [STACK_AW:0]   sp
`ifdef MPU_SEQ_STEP_EN
  ,
  input  logic                step_mode,
  input  logic                step,
  output logic                paused
`endif
);

  localparam int unsigned SP_W = STACK_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
`ifdef MPU_SEQ_STEP_EN
    ,
    S_PAUSE = 3'd5
`endif
  } state_t;

  state_t state_q;
  state_t run_state_c;

  logic [15:0]         stack_q [STACK_DEPTH];
  logic [STACK_AW-1:0] push_idx_c;
  logic [STACK_AW-1:0] pop_idx_c;
  logic [15:0]         link_addr_c;
  logic                go_c, take_c;
  logic                halt_c, ret_c, call_c, jmp_c, seq_c;
  logic                push_c, pop_c, fault_c;
  logic                stack_empty_c, stack_full_c;

  // Outcome decode: stop and reset override everything issued this cycle.
  always_comb begin
    go_c          = !sys_rst && !stop;
    take_c        = go_c && (state_q == S_EXEC) && exec_done;
    halt_c        = take_c && exec_halt;
    ret_c         = take_c && !exec_halt && exec_ret;
    call_c        = take_c && !exec_halt && !exec_ret && exec_call;
    jmp_c         = take_c && !exec_halt && !exec_ret && !exec_call && exec_jmp;
    seq_c         = take_c && !exec_halt && !exec_ret && !exec_call && !exec_jmp;
    stack_empty_c = (sp == '0);
    stack_full_c  = (sp == SP_W'(STACK_DEPTH));
    push_c        = call_c && !stack_full_c;
    pop_c         = ret_c && !stack_empty_c;
    fault_c       = (call_c && stack_full_c) || (ret_c && stack_empty_c);
    push_idx_c    = sp[STACK_AW-1:0];
    pop_idx_c     = sp[STACK_AW-1:0] - STACK_AW'(1);
    link_addr_c   = ip + exec_len;
  end

  // Where a completed instruction goes next when it neither halts nor faults.
  always_comb begin
    run_state_c = S_FETCH;
`ifdef MPU_SEQ_STEP_EN
    if (step_mode) run_state_c = S_PAUSE;
`endif
  end

  // Counter controls; the counter updates on the next edge.
  always_comb begin
    ip_en   = 1'b0;
    ip_load = 1'b0;
    ip_incr = 16'h0000;
    ip_data = 16'h0000;
    if (go_c && (state_q == S_IDLE) && start) begin
      ip_en   = 1'b1;
      ip_load = 1'b1;
      ip_data = start_addr;
    end else if (pop_c) begin
      ip_en   = 1'b1;
      ip_load = 1'b1;
      ip_data = stack_q[pop_idx_c];
    end else if (push_c || jmp_c) begin
      ip_en   = 1'b1;
      ip_load = 1'b1;
      ip_data = exec_target;
    end else if (seq_c) begin
      ip_en   = 1'b1;
      ip_incr = exec_len;
    end
  end

  // Sequencer state, stack pointer and instruction latch.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      sp      <= '0;
      instr   <= 16'h0000;
    end else if (stop) begin
      state_q <= S_IDLE;
      sp      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            instr   <= mem_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            if (halt_c)       state_q <= S_HALT;
            else if (fault_c) state_q <= S_ERR;
            else              state_q <= run_state_c;
            if (push_c)       sp <= sp + SP_W'(1);
            else if (pop_c)   sp <= sp - SP_W'(1);
          end
        end
`ifdef MPU_SEQ_STEP_EN
        S_PAUSE: if (step) state_q <= S_FETCH;
`endif
        default: ; // HALT and ERR hold until stop or reset
      endcase
    end
  end

  // Return-address storage; only the pointer is ever cleared.
  always_ff @(posedge sys_clk) begin
    if (push_c) stack_q[push_idx_c] <= link_addr_c;
  end

  assign mem_req     = go_c && (state_q == S_FETCH);
  assign mem_addr    = ip;
  assign instr_valid = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign err         = (state_q == S_ERR);
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
`ifdef MPU_SEQ_STEP_EN
  assign paused      = (state_q == S_PAUSE);
`endif

endmodule

// File: tb/tb_mpu_seq.sv
// tb_mpu_seq: directed bench for mpu_seq with an external counter model, a
// fetch responder and a scoreboard monitor that checks each accepted fetch
// address and each word handed to the decoder.

module tb_mpu_seq;

  logic        sys_clk = 1'b0;
  logic        sys_rst, start, stop, mem_ack, exec_done;
  logic        exec_jmp, exec_call, exec_ret, exec_halt;
  logic [15:0] start_addr, mem_data, exec_len, exec_target;
  logic [15:0] ip;
  logic        ip_en, ip_load, mem_req, instr_valid, busy, halted, err;
  logic [15:0] ip_incr, ip_data, mem_addr, instr;
  logic [3:0]  sp;
`ifdef MPU_SEQ_STEP_EN
  logic        step_mode, step, paused;
`endif

  int nvec  = 0;
  int nfail = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];
  logic        iv_d = 1'b0;

  mpu_seq #(.STACK_DEPTH(8), .STACK_AW(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .start_addr(start_addr),
    .stop(stop), .ip(ip), .ip_en(ip_en), .ip_load(ip_load), .ip_incr(ip_incr),
    .ip_data(ip_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .exec_len(exec_len), .exec_jmp(exec_jmp),
    .exec_call(exec_call), .exec_ret(exec_ret), .exec_halt(exec_halt),
    .exec_target(exec_target), .busy(busy), .halted(halted), .err(err), .sp(sp)
`ifdef MPU_SEQ_STEP_EN
    , .step_mode(step_mode), .step(step), .paused(paused)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Instruction pointer counter driven by the sequencer.
  always @(posedge sys_clk) begin
    if (sys_rst)    ip <= 16'h0000;
    else if (ip_en) ip <= ip_load ? ip_data : ip + ip_incr;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: accepted fetches and decoder hand-offs.
  always @(negedge sys_clk) begin
    if (!sys_rst && mem_req && mem_ack) begin
      if (exp_addr_q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL unexpected_fetch: got addr %h expected none", mem_addr);
      end else chk("fetch_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (instr_valid && !iv_d) begin
      if (exp_instr_q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL unexpected_exec: got instr %h expected none", instr);
      end else chk("instr", 32'(instr), 32'(exp_instr_q.pop_front()));
    end
    iv_d <= instr_valid;
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic fetch(input logic [15:0] addr, input logic [15:0] word, input int lat);
    int n = 0;
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back(word);
    while (!mem_req && n < 50) begin tick(); n++; end
    if (!mem_req) chk("fetch_timeout", 32'(mem_req), 32'd1);
    repeat (lat) tick();
    mem_ack = 1'b1; mem_data = word;
    tick();
    mem_ack = 1'b0; mem_data = 16'h0000;
  endtask

  task automatic exec(input logic [15:0] len, input logic jmp, input logic call,
                      input logic ret, input logic halt, input logic [15:0] tgt);
    exec_done = 1'b1; exec_len = len; exec_jmp = jmp; exec_call = call;
    exec_ret = ret; exec_halt = halt; exec_target = tgt;
    tick();
    exec_done = 1'b0; exec_len = 16'h0000; exec_jmp = 1'b0; exec_call = 1'b0;
    exec_ret = 1'b0; exec_halt = 1'b0; exec_target = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; start = 1'b0; stop = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    exec_jmp = 1'b0; exec_call = 1'b0; exec_ret = 1'b0; exec_halt = 1'b0;
    start_addr = 16'h0000; mem_data = 16'h0000; exec_len = 16'h0000; exec_target = 16'h0000;
`ifdef MPU_SEQ_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    tick(); tick();
    sys_rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_status", {29'd0, halted, err, instr_valid}, 0);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_ctrl", {13'd0, ip_en, ip_load, mem_req, ip_incr}, 0);
    chk("rst_ip_data", 32'(ip_data), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);

    // Sequential run from 0x0100 with exec_len 2.
    start = 1'b1; start_addr = 16'h0100;
    #1;
    chk("start_ctrl", {30'd0, ip_en, ip_load}, 32'd3);
    chk("start_data", 32'(ip_data), 32'h0100);
    tick();
    start = 1'b0;
    chk("busy_fetch", 32'(busy), 1);
    fetch(16'h0100, 16'h1111, 3);
    exec(16'd2, 0, 0, 0, 0, 16'h0000);
    fetch(16'h0102, 16'h2222, 0);
    exec(16'd2, 0, 0, 0, 0, 16'h0000);
    fetch(16'h0104, 16'h3333, 1);
    exec(16'd2, 0, 0, 0, 0, 16'h0000);
    fetch(16'h0106, 16'h4444, 0);

    // Jump to 0x0010, call 0x0200, return to 0x0011.
    exec(16'd3, 1, 0, 0, 0, 16'h0010);
    fetch(16'h0010, 16'h0C01, 0);
    chk("sp_before_call", 32'(sp), 0);
    exec(16'd1, 1, 1, 0, 0, 16'h0200);
    chk("sp_after_call", 32'(sp), 1);
    fetch(16'h0200, 16'h0E00, 2);
    exec(16'd1, 1, 1, 1, 0, 16'h0999);
    chk("sp_after_ret", 32'(sp), 0);
    fetch(16'h0011, 16'h0011, 0);

    // Nine nested calls overflow an eight-entry stack.
    for (int i = 0; i < 8; i++) begin
      exec(16'd1, 0, 1, 0, 0, 16'(16'h0300 + 16 * i));
      fetch(16'(16'h0300 + 16 * i), 16'(16'hC000 + i), 0);
    end
    chk("sp_full", 32'(sp), 8);
    exec_done = 1'b1; exec_len = 16'd1; exec_call = 1'b1; exec_target = 16'h0400;
    #1;
    chk("overflow_no_load", 32'(ip_en), 0);
    tick();
    exec_done = 1'b0; exec_call = 1'b0; exec_len = 16'h0; exec_target = 16'h0;
    chk("overflow_err", {29'd0, err, busy, halted}, 32'd4);
    chk("overflow_ip", 32'(mem_addr), 32'h0370);
    start = 1'b1; start_addr = 16'h0AAA;
    tick();
    start = 1'b0;
    chk("err_holds", {30'd0, err, busy}, 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_clears", {28'd0, sp}, 0);
    chk("stop_status", {29'd0, err, busy, halted}, 0);

    // Wrap from 0xFFFF, then halt (halt beats jump).
    start = 1'b1; start_addr = 16'hFFFF;
    tick();
    start = 1'b0;
    fetch(16'hFFFF, 16'hF00F, 0);
    exec(16'd1, 0, 0, 0, 0, 16'h0000);
    fetch(16'h0000, 16'h5A5A, 1);
    exec(16'd1, 1, 0, 0, 1, 16'h1234);
    chk("halted", {29'd0, halted, busy, mem_req}, 32'd4);
    chk("halt_ip", 32'(mem_addr), 32'h0000);
    start = 1'b1; start_addr = 16'h0900;
    #1;
    chk("halt_ignores_start", 32'(ip_en), 0);
    tick();
    start = 1'b0;
    chk("still_halted", 32'(halted), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("halt_stop", 32'(halted), 0);

    // stop beats mem_ack: no decoder hand-off, instr unchanged.
    start = 1'b1; start_addr = 16'h0500;
    tick();
    start = 1'b0;
    mem_ack = 1'b1; mem_data = 16'hBEEF; stop = 1'b1;
    #1;
    chk("stop_drops_req", 32'(mem_req), 0);
    tick();
    mem_ack = 1'b0; mem_data = 16'h0; stop = 1'b0;
    chk("stop_instr_kept", 32'(instr), 32'h5A5A);
    chk("stop_no_exec", {30'd0, instr_valid, busy}, 0);
    tick();
    chk("stop_ip_kept", 32'(mem_addr), 32'h0500);

    // Reset while executing with a non-empty stack.
    start = 1'b1; start_addr = 16'h0600;
    tick();
    start = 1'b0;
    fetch(16'h0600, 16'h6666, 0);
    exec(16'd2, 0, 1, 0, 0, 16'h0700);
    fetch(16'h0700, 16'h7777, 0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rstx_instr", 32'(instr), 0);
    chk("rstx_sp", 32'(sp), 0);
    chk("rstx_status", {27'd0, instr_valid, busy, halted, err, mem_req}, 0);
    chk("rstx_ip", 32'(mem_addr), 0);

    // Reset mid-fetch discards an in-flight ack.
    start = 1'b1; start_addr = 16'h0650;
    tick();
    start = 1'b0;
    sys_rst = 1'b1; mem_ack = 1'b1; mem_data = 16'h9999;
    tick();
    sys_rst = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;
    chk("rstf_instr", 32'(instr), 0);
    chk("rstf_busy", 32'(busy), 0);

`ifdef MPU_SEQ_STEP_EN
    // Single-step: pause after each instruction, resume on step.
    step_mode = 1'b1;
    start = 1'b1; start_addr = 16'h0800;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fetch(16'(16'h0800 + k), 16'(16'h8800 + k), 0);
      exec(16'd1, 0, 0, 0, 0, 16'h0000);
      chk("step_paused", {30'd0, paused, mem_req}, 32'd2);
      tick();
      chk("step_hold", {30'd0, paused, mem_req}, 32'd2);
      step = 1'b1;
      #1;
      chk("step_req_wait", 32'(mem_req), 0);
      tick();
      step = 1'b0;
      chk("step_resume", {30'd0, paused, mem_req}, 32'd1);
    end
    fetch(16'h0803, 16'h8803, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    step_mode = 1'b0;
    chk("step_stop", 32'(busy), 0);
`endif

    tick(); tick();
    chk("addr_queue_empty", 32'(exp_addr_q.size()), 0);
    chk("instr_queue_empty", 32'(exp_instr_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
